// File: rtl/zbt_port_arbiter.sv
// Two-port arbiter in front of a pipelined ZBT SRAM: display reads have fixed priority, decoder reads/writes fill spare slots.
// Optional starvation guard enabled by defining ZBT_ARB_STARVE_EN.
module zbt_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              dec_req,
  input  logic              dec_we,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] dec_wdata,
  output logic              dec_gnt,
  output logic              dec_rvalid,
  output logic [DATA_W-1:0] dec_rdata,
  output logic [ADDR_W-1:0] ZBT_addr,
  output logic              ZBT_we_n,
  output logic [DATA_W-1:0] ZBT_dataout,
  output logic              ZBT_oe,
  input  logic [DATA_W-1:0] ZBT_datain
);

  // state  | meaning
  // S_IDLE | previous slot unused
  // S_DISP | previous slot granted to the display
  // S_DEC  | previous slot granted to the decoder
  typedef enum logic [1:0] {S_IDLE, S_DISP, S_DEC} state_t;

  state_t            state;
  logic              force_slot;
  logic              tw0;
  logic [READ_LAT:1] tv_q, to_q, tw_q;
  logic [READ_LAT:0] tv, to, tw;
  logic [DATA_W-1:0] wd [READ_LAT];

`ifdef ZBT_ARB_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  assign force_slot = dec_req && (wait_cnt == WW'(MAX_WAIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      wait_cnt <= '0;
    else if (!dec_req || dec_gnt)
      wait_cnt <= '0;
    else if (wait_cnt != WW'(MAX_WAIT))
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign force_slot = 1'b0;
`endif

  assign disp_gnt = disp_req && !force_slot;
  assign dec_gnt  = dec_req && !disp_gnt;

  // The FSM state doubles as stage 0 of the tag pipeline (owner of the slot now on the pins).
  assign tv = {tv_q, state != S_IDLE};
  assign to = {to_q, state == S_DISP};
  assign tw = {tw_q, tw0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      tw0         <= 1'b0;
      tv_q        <= '0;
      to_q        <= '0;
      tw_q        <= '0;
      for (int k = 0; k < READ_LAT; k++) wd[k] <= '0;
      ZBT_addr    <= '0;
      ZBT_we_n    <= 1'b1;
      ZBT_oe      <= 1'b0;
      ZBT_dataout <= '0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      dec_rvalid  <= 1'b0;
      dec_rdata   <= '0;
    end else begin
      if (disp_gnt) begin
        state    <= S_DISP;
        ZBT_addr <= disp_addr;
      end else if (dec_gnt) begin
        state    <= S_DEC;
        ZBT_addr <= dec_addr;
      end else begin
        state    <= S_IDLE;
      end
      ZBT_we_n <= !(dec_gnt && dec_we);
      tw0      <= dec_gnt && dec_we;
      if (dec_gnt && dec_we) wd[0] <= dec_wdata;
      for (int k = 1; k < READ_LAT; k++) wd[k] <= wd[k-1];
      tv_q <= tv[READ_LAT-1:0];
      to_q <= to[READ_LAT-1:0];
      tw_q <= tw[READ_LAT-1:0];

      // Write data is driven in the cycle the SRAM expects it, READ_LAT after the address.
      ZBT_oe <= tv[READ_LAT-1] && tw[READ_LAT-1];
      if (tv[READ_LAT-1] && tw[READ_LAT-1]) ZBT_dataout <= wd[READ_LAT-1];

      disp_rvalid <= tv[READ_LAT] && to[READ_LAT] && !tw[READ_LAT];
      if (tv[READ_LAT] && to[READ_LAT] && !tw[READ_LAT]) disp_rdata <= ZBT_datain;
      dec_rvalid  <= tv[READ_LAT] && !to[READ_LAT] && !tw[READ_LAT];
      if (tv[READ_LAT] && !to[READ_LAT] && !tw[READ_LAT]) dec_rdata <= ZBT_datain;
    end
  end

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Scoreboard bench for zbt_port_arbiter against a pin-level ZBT SRAM model and a grant-order memory reference.
// Starvation-guard expectations follow ZBT_ARB_STARVE_EN.
module tb_zbt_port_arbiter;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int MW = 8;
  localparam int STREAM_N = 2000;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic          d_req = 0, w_req = 0, w_we = 0;
  logic [AW-1:0] d_addr = '0, w_addr = '0;
  logic [DW-1:0] w_wdata = '0;
  logic          disp_gnt, disp_rvalid, dec_gnt, dec_rvalid, ZBT_we_n, ZBT_oe;
  logic [DW-1:0] disp_rdata, dec_rdata, ZBT_dataout;
  logic [DW-1:0] ZBT_datain = '0;
  logic [AW-1:0] ZBT_addr;

  zbt_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .MAX_WAIT(MW)) dut (
    .clk(clk), .resetn(resetn),
    .disp_req(d_req), .disp_addr(d_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .dec_req(w_req), .dec_we(w_we), .dec_addr(w_addr), .dec_wdata(w_wdata),
    .dec_gnt(dec_gnt), .dec_rvalid(dec_rvalid), .dec_rdata(dec_rdata),
    .ZBT_addr(ZBT_addr), .ZBT_we_n(ZBT_we_n), .ZBT_dataout(ZBT_dataout),
    .ZBT_oe(ZBT_oe), .ZBT_datain(ZBT_datain)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(int a);
    logic [31:0] x;
    x = a;
    return (a == 8) ? 32'hA1B2C3D4 : ((x * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Pin-side SRAM: address on pins at cycle n, data on ZBT_datain at n+RL; writes land when ZBT_oe is high.
  logic [DW-1:0] pin_mem [int];
  logic [AW-1:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    if (ZBT_oe) pin_mem[int'(p1)] = ZBT_dataout;
    ZBT_datain <= pin_mem.exists(int'(p0)) ? pin_mem[int'(p0)] : init_val(int'(p0));
    p1 <= p0;
    p0 <= ZBT_addr;
  end

  // Reference: memory updated in grant order; each grant yields timed expectations.
  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  typedef struct { logic [AW-1:0] a; logic we_n; int due; } pin_t;
  exp_t dq[$], wq[$], oq[$];
  pin_t pq[$];
  logic [DW-1:0] ref_mem [int];
  logic [AW-1:0] last_addr = '0;
  logic m_dg = 0, m_wg = 0;
  int waits = 0, phase = 0, cidx = 0, gcount = 0, gfirst = -1;

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
  endfunction

  always @(negedge clk) begin
    logic frc;
    if (!resetn) begin
      m_dg = 0; m_wg = 0; waits = 0;
    end else begin
`ifdef ZBT_ARB_STARVE_EN
      frc = w_req && (waits == MW);
`else
      frc = 1'b0;
`endif
      m_dg = d_req && !frc;
      m_wg = w_req && !m_dg;
      chk("disp_gnt", 64'(disp_gnt), 64'(m_dg));
      chk("dec_gnt", 64'(dec_gnt), 64'(m_wg));
      if (m_dg) begin
        pq.push_back('{d_addr, 1'b1, cyc + 1});
        dq.push_back('{ref_rd(d_addr), cyc + 2 + RL});
      end
      if (m_wg) begin
        pq.push_back('{w_addr, !w_we, cyc + 1});
        if (w_we) begin
          ref_mem[int'(w_addr)] = w_wdata;
          oq.push_back('{w_wdata, cyc + 1 + RL});
        end else begin
          wq.push_back('{ref_rd(w_addr), cyc + 2 + RL});
        end
      end
      if (!w_req || m_wg) waits = 0;
      else if (waits < MW) waits++;
      if (phase == 2) begin
        if (dec_gnt) begin
          gcount++;
          if (gfirst < 0) gfirst = cidx;
        end
        cidx++;
      end
    end
  end

  // Monitor: pops an expectation whenever its cycle arrives and compares what the DUT presents.
  always @(negedge clk) begin
    logic ev;
    ev = dq.size() > 0 && dq[0].due == cyc;
    chk("disp_rvalid", 64'(disp_rvalid), 64'(ev));
    if (ev) begin chk("disp_rdata", 64'(disp_rdata), 64'(dq[0].data)); void'(dq.pop_front()); end
    ev = wq.size() > 0 && wq[0].due == cyc;
    chk("dec_rvalid", 64'(dec_rvalid), 64'(ev));
    if (ev) begin chk("dec_rdata", 64'(dec_rdata), 64'(wq[0].data)); void'(wq.pop_front()); end
    ev = oq.size() > 0 && oq[0].due == cyc;
    chk("zbt_oe", 64'(ZBT_oe), 64'(ev));
    if (ev) begin chk("zbt_dataout", 64'(ZBT_dataout), 64'(oq[0].data)); void'(oq.pop_front()); end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      chk("zbt_addr", 64'(ZBT_addr), 64'(pq[0].a));
      chk("zbt_we_n", 64'(ZBT_we_n), 64'(pq[0].we_n));
      last_addr = pq[0].a;
      void'(pq.pop_front());
    end else begin
      chk("zbt_we_n_idle", 64'(ZBT_we_n), 64'd1);
      chk("zbt_addr_hold", 64'(ZBT_addr), 64'(last_addr));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    d_req = 0; w_req = 0;
    repeat (n) step();
  endtask

  task automatic flush();
    dq.delete(); wq.delete(); oq.delete(); pq.delete();
    last_addr = '0;
  endtask

  task automatic disp_read8();
    d_req = 1; d_addr = 19'h00008;
    step();
    d_req = 0;
    idle(8);
  endtask

  initial begin
    int n;
    #1 resetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_disp_gnt", 64'(disp_gnt), 64'd0);
    chk("rst_dec_gnt", 64'(dec_gnt), 64'd0);
    chk("rst_disp_rdata", 64'(disp_rdata), 64'd0);
    chk("rst_dec_rdata", 64'(dec_rdata), 64'd0);
    chk("rst_dataout", 64'(ZBT_dataout), 64'd0);
    chk("rst_zbt_addr", 64'(ZBT_addr), 64'd0);
    @(posedge clk); #1 resetn = 1;
    step();

    disp_read8();

    w_req = 1; w_we = 1; w_addr = 19'h1FA40; w_wdata = 32'h0000_1234;
    step();
    w_we = 0;
    step();
    w_req = 0;
    idle(8);

    // Contention: display held for 20 cycles against a continuously requesting decoder.
    phase = 2;
    d_req = 1; d_addr = AW'($urandom);
    w_req = 1; w_we = 0; w_addr = AW'($urandom); w_wdata = $urandom;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 19) begin phase = 0; d_req = 0; end
      else if (m_dg) d_addr = AW'($urandom);
      if (m_wg) begin w_we = 1'($urandom); w_addr = AW'($urandom); w_wdata = $urandom; end
    end
    n = 0;
    while (!m_wg && n < 50) begin step(); n++; end
    if (n >= 50) chk("dec_gnt_timeout", 64'(n), 64'd0);
    w_req = 0;
    idle(8);
`ifdef ZBT_ARB_STARVE_EN
    chk("starve_first_gnt", 64'(gfirst), 64'd8);
    chk("starve_gnt_count", 64'(gcount), 64'd2);
`else
    chk("strict_gnt_count", 64'(gcount), 64'd0);
`endif

    d_req = 1; d_addr = '0; n = 0;
    while (d_req && n < 3 * STREAM_N) begin
      step(); n++;
      if (m_dg) d_addr = d_addr + 1'b1;
      if (d_addr == AW'(STREAM_N)) d_req = 0;
    end
    chk("stream_cycles", 64'(n), 64'(STREAM_N));
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      step();
      if (m_dg || !d_req) begin d_req = ($urandom % 100) < 40; d_addr = AW'($urandom % 64); end
      else if (($urandom % 100) < 5) d_req = 0;
      if (m_wg || !w_req) begin
        w_req = ($urandom % 100) < 60; w_we = 1'($urandom);
        w_addr = AW'($urandom % 64); w_wdata = $urandom;
      end else if (($urandom % 100) < 5) w_req = 0;
    end
    idle(8);

    // Reset with two display reads in flight; nothing may come back.
    d_req = 1; d_addr = 19'h00010;
    step();
    d_addr = 19'h00011;
    step();
    d_req = 0; resetn = 0; flush();
    repeat (4) step();
    resetn = 1;
    step();
    idle(6);
    disp_read8();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1);
  end
endmodule
